// File: rtl/snoop_bus_arbiter.sv
// Round-robin arbiter and request muxer for the shared snooping bus.
// Latches the winner's transaction fields and holds them until the engine completes or the watchdog fires.
module snoop_bus_arbiter #(
  parameter int unsigned N_PROC  = 3,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_PROC-1:0]     req,
  input  logic [3*N_PROC-1:0]   req_tag,
  input  logic [2*N_PROC-1:0]   req_pos,
  input  logic [N_PROC-1:0]     req_op,
  input  logic [16*N_PROC-1:0]  req_data,
  input  logic                  bus_done,
  output logic [N_PROC-1:0]     grant,
  output logic                  bus_valid,
  output logic [1:0]            bus_proc_num,
  output logic [2:0]            bus_tag,
  output logic [1:0]            bus_pos,
  output logic                  bus_op,
  output logic [15:0]           bus_data,
  output logic [N_PROC-1:0]     ack,
  output logic [N_PROC-1:0]     err
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } state_e;

  state_e              state_q;
  logic [N_PROC-1:0]   grant_q;
  logic                valid_q;
  logic [1:0]          proc_q;
  logic [2:0]          tag_q;
  logic [1:0]          pos_q;
  logic                op_q;
  logic [15:0]         data_q;
  logic [N_PROC-1:0]   ack_q;
  logic [N_PROC-1:0]   err_q;
  logic [CW-1:0]       cnt_q;
  logic [1:0]          last_q;

  logic                win_found_d;
  logic [1:0]          win_idx_d;
  logic [N_PROC-1:0]   grant_d;
  logic [2:0]          tag_d;
  logic [1:0]          pos_d;
  logic                op_d;
  logic [15:0]         data_d;
  logic                timeout_hit;

  // Scan priority slots last+1, last+2, ... and mux the first requester's fields;
  // the inner loop keeps every field select constant.
  always_comb begin
    win_found_d = 1'b0;
    win_idx_d   = '0;
    grant_d     = '0;
    tag_d       = '0;
    pos_d       = '0;
    op_d        = 1'b0;
    data_d      = '0;
    for (int unsigned i = 1; i <= N_PROC; i++) begin
      for (int unsigned k = 0; k < N_PROC; k++) begin
        if (!win_found_d && (k == ((32'(last_q) + i) % N_PROC)) && req[k]) begin
          win_found_d = 1'b1;
          win_idx_d   = 2'(k);
          grant_d[k]  = 1'b1;
          tag_d       = req_tag[3*k +: 3];
          pos_d       = req_pos[2*k +: 2];
          op_d        = req_op[k];
          data_d      = req_data[16*k +: 16];
        end
      end
    end
  end

  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      valid_q <= 1'b0;
      proc_q  <= '0;
      tag_q   <= '0;
      pos_q   <= '0;
      op_q    <= 1'b0;
      data_q  <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 2'(N_PROC - 1);
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= '0;
          err_q <= '0;
          if (win_found_d) begin
            grant_q <= grant_d;
            valid_q <= 1'b1;
            proc_q  <= win_idx_d;
            tag_q   <= tag_d;
            pos_q   <= pos_d;
            op_q    <= op_d;
            data_q  <= data_d;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + CW'(1);
          // grant_q is one-hot on the owner, so it doubles as the ack/err mask.
          if (bus_done) begin
            grant_q <= '0;
            valid_q <= 1'b0;
            ack_q   <= grant_q;
            last_q  <= proc_q;
            state_q <= RELEASE;
          end else if (timeout_hit) begin
            grant_q <= '0;
            valid_q <= 1'b0;
            err_q   <= grant_q;
            last_q  <= proc_q;
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          ack_q   <= '0;
          err_q   <= '0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant        = grant_q;
  assign bus_valid    = valid_q;
  assign bus_proc_num = proc_q;
  assign bus_tag      = tag_q;
  assign bus_pos      = pos_q;
  assign bus_op       = op_q;
  assign bus_data     = data_q;
  assign ack          = ack_q;
  assign err          = err_q;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter: grant/latch, rotation, frozen fields, watchdog, tie-break, reset abort.
module tb_snoop_bus_arbiter;

  logic        clock;
  logic        reset;
  logic [2:0]  req;
  logic [8:0]  req_tag;
  logic [5:0]  req_pos;
  logic [2:0]  req_op;
  logic [47:0] req_data;
  logic        bus_done;
  logic [2:0]  grant;
  logic        bus_valid;
  logic [1:0]  bus_proc_num;
  logic [2:0]  bus_tag;
  logic [1:0]  bus_pos;
  logic        bus_op;
  logic [15:0] bus_data;
  logic [2:0]  ack;
  logic [2:0]  err;

  int passed;
  int total;

  snoop_bus_arbiter #(.N_PROC(3), .TIMEOUT(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .req_tag      (req_tag),
    .req_pos      (req_pos),
    .req_op       (req_op),
    .req_data     (req_data),
    .bus_done     (bus_done),
    .grant        (grant),
    .bus_valid    (bus_valid),
    .bus_proc_num (bus_proc_num),
    .bus_tag      (bus_tag),
    .bus_pos      (bus_pos),
    .bus_op       (bus_op),
    .bus_data     (bus_data),
    .ack          (ack),
    .err          (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    logic [2:0] exp_seq [4];
    passed   = 0;
    total    = 0;
    reset    = 1'b1;
    req      = '0;
    req_tag  = '0;
    req_pos  = '0;
    req_op   = '0;
    req_data = '0;
    bus_done = 1'b0;
    tick(2);
    check("rst_grant", 16'(grant), 16'h0);
    check("rst_valid", 16'(bus_valid), 16'h0);
    check("rst_ack", 16'(ack), 16'h0);
    check("rst_err", 16'(err), 16'h0);
    check("rst_data", bus_data, 16'h0);
    reset = 1'b0;

    // bus_done while idle is ignored
    bus_done = 1'b1;
    tick(1);
    bus_done = 1'b0;
    check("idle_done_ack", 16'(ack), 16'h0);
    check("idle_done_valid", 16'(bus_valid), 16'h0);

    // Test 1: single requester proc 1
    req          = 3'b010;
    req_tag[5:3] = 3'd5;
    req_pos[3:2] = 2'd2;
    req_op[1]    = 1'b1;
    tick(1);
    check("t1_grant", 16'(grant), 16'h2);
    check("t1_proc", 16'(bus_proc_num), 16'h1);
    check("t1_tag", 16'(bus_tag), 16'h5);
    check("t1_pos", 16'(bus_pos), 16'h2);
    check("t1_op", 16'(bus_op), 16'h1);
    check("t1_valid", 16'(bus_valid), 16'h1);
    tick(3);
    check("t1_busy4_ack", 16'(ack), 16'h0);
    bus_done = 1'b1;
    tick(1);
    bus_done = 1'b0;
    check("t1_ack", 16'(ack), 16'h2);
    check("t1_rel_grant", 16'(grant), 16'h0);
    check("t1_rel_valid", 16'(bus_valid), 16'h0);
    req = '0;
    tick(1);
    check("t1_ack_clear", 16'(ack), 16'h0);

    // Test 2: rotation from reset with all requesters held
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    req = 3'b111;
    exp_seq[0] = 3'b001;
    exp_seq[1] = 3'b010;
    exp_seq[2] = 3'b100;
    exp_seq[3] = 3'b001;
    for (int t = 0; t < 4; t++) begin
      tick(1);
      check($sformatf("t2_grant%0d", t), 16'(grant), 16'(exp_seq[t]));
      tick(4);
      bus_done = 1'b1;
      tick(1);
      bus_done = 1'b0;
      check($sformatf("t2_ack%0d", t), 16'(ack), 16'(exp_seq[t]));
      check($sformatf("t2_relgrant%0d", t), 16'(grant), 16'h0);
      tick(1);
    end

    // Test 3: fields frozen while busy
    req             = 3'b001;
    req_data[15:0]  = 16'd8;
    tick(1);
    check("t3_grant", 16'(grant), 16'h1);
    check("t3_data_latched", bus_data, 16'd8);
    req_data[15:0] = 16'd30;
    tick(2);
    check("t3_data_frozen", bus_data, 16'd8);
    bus_done = 1'b1;
    tick(1);
    bus_done = 1'b0;
    check("t3_ack", 16'(ack), 16'h1);
    req = '0;
    tick(1);

    // Test 4: watchdog on proc 2
    req = 3'b100;
    tick(1);
    check("t4_grant", 16'(grant), 16'h4);
    tick(15);
    check("t4_busy16_grant", 16'(grant), 16'h4);
    check("t4_busy16_err", 16'(err), 16'h0);
    tick(1);
    check("t4_err", 16'(err), 16'h4);
    check("t4_ack", 16'(ack), 16'h0);
    check("t4_rel_grant", 16'(grant), 16'h0);
    req = '0;
    tick(1);
    check("t4_err_clear", 16'(err), 16'h0);
    req = 3'b101;
    tick(1);
    check("t4_next_grant", 16'(grant), 16'h1);

    // Test 5: bus_done on the timeout cycle wins
    tick(15);
    bus_done = 1'b1;
    tick(1);
    bus_done = 1'b0;
    check("t5_ack", 16'(ack), 16'h1);
    check("t5_err", 16'(err), 16'h0);
    req = '0;
    tick(1);

    // Test 6: reset mid-busy aborts silently, priority restored
    req = 3'b010;
    tick(1);
    check("t6_grant", 16'(grant), 16'h2);
    tick(2);
    reset = 1'b1;
    req   = '0;
    tick(1);
    check("t6_rst_grant", 16'(grant), 16'h0);
    check("t6_rst_valid", 16'(bus_valid), 16'h0);
    check("t6_rst_ack", 16'(ack), 16'h0);
    check("t6_rst_err", 16'(err), 16'h0);
    reset = 1'b0;
    req   = 3'b111;
    tick(1);
    check("t6_first_grant", 16'(grant), 16'h1);
    check("t6_post_ack", 16'(ack), 16'h0);
    check("t6_post_err", 16'(err), 16'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
